// File: rtl/cpu_acc_pkg.sv
// ============================================================================
// Module   : cpu_acc_pkg
// Purpose  : Opcodes, branch sub-ops, state encoding and PSW layout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_acc_pkg;

  localparam logic [3:0] c_op_ld   = 4'h0;
  localparam logic [3:0] c_op_st   = 4'h1;
  localparam logic [3:0] c_op_in   = 4'h2;
  localparam logic [3:0] c_op_out  = 4'h3;
  localparam logic [3:0] c_op_add  = 4'h4;
  localparam logic [3:0] c_op_sub  = 4'h5;
  localparam logic [3:0] c_op_br   = 4'h6;
  localparam logic [3:0] c_op_and  = 4'h7;
  localparam logic [3:0] c_op_reti = 4'hE;
  localparam logic [3:0] c_op_trap = 4'hF;

  localparam logic [3:0] c_br_jmp = 4'h0;
  localparam logic [3:0] c_br_jz  = 4'h2;
  localparam logic [3:0] c_br_jnz = 4'h3;
  localparam logic [3:0] c_br_jn  = 4'h4;
  localparam logic [3:0] c_br_jc  = 4'h5;

  localparam int c_psw_n  = 3;
  localparam int c_psw_z  = 2;
  localparam int c_psw_c  = 1;
  localparam int c_psw_ie = 0;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_DECODE     = 3'd1,
    ST_OPERAND    = 3'd2,
    ST_EXECUTE    = 3'd3,
    ST_TRAP_ENTRY = 3'd4,
    ST_HALT       = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2
  } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/cpu_alu_flags.sv
// ============================================================================
// Module   : cpu_alu_flags
// Purpose  : Combinational ADD/SUB/AND with N/Z/C flag generation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_alu_flags
  import cpu_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_op_t               op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  n,
  output logic                  z,
  output logic                  c
);

  logic [DATA_WIDTH:0] w_sum;

  // SUB is a + ~b + 1, so carry-out reads as "no borrow"
  always_comb begin
    w_sum  = '0;
    result = '0;
    c      = 1'b0;
    case (op)
      ALU_ADD: begin
        w_sum  = {1'b0, a} + {1'b0, b};
        result = w_sum[DATA_WIDTH-1:0];
        c      = w_sum[DATA_WIDTH];
      end
      ALU_SUB: begin
        w_sum  = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};
        result = w_sum[DATA_WIDTH-1:0];
        c      = w_sum[DATA_WIDTH];
      end
      ALU_AND: begin
        result = a & b;
        c      = 1'b0;
      end
      default: begin
        result = '0;
        c      = 1'b0;
      end
    endcase
    n = result[DATA_WIDTH-1];
    z = (result == '0);
  end

endmodule

`default_nettype wire

// File: rtl/cpu_acc_param.sv
// ============================================================================
// Module   : cpu_acc_param
// Purpose  : Parametrised accumulator CPU with wait-state memory and traps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_acc_param
  import cpu_acc_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int RESET_VECTOR = 0,
  parameter int TRAP_VECTOR  = 'hF0,
  parameter bit IE_RESET     = 1'b0
) (
  input  logic                  clk,
  input  logic                  async_nreset,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] io_data_input,
  output logic [DATA_WIDTH-1:0] io_data_output,
  output logic                  io_write,
  input  logic                  trap_trigger,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] c_reset_pc = ADDR_WIDTH'(RESET_VECTOR);
  localparam logic [ADDR_WIDTH-1:0] c_trap_pc  = ADDR_WIDTH'(TRAP_VECTOR);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_epc;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_ir0;
  logic [DATA_WIDTH-1:0] r_ir1;
  logic [3:0]            r_psw;
  logic [3:0]            r_epsw;
  logic                  r_irq_pending;
  logic                  r_trig_q;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_io_write;
  logic [DATA_WIDTH-1:0] r_io_data;
  logic                  r_halted;

  logic [3:0]            w_opcode;
  logic [3:0]            w_subop;
  logic                  w_irq_edge;
  logic                  w_br_valid;
  logic                  w_br_taken;
  alu_op_t               w_alu_op;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_alu_n;
  logic                  w_alu_z;
  logic                  w_alu_c;

  assign w_opcode   = r_ir0[DATA_WIDTH-1 -: 4];
  assign w_subop    = r_ir0[3:0];
  assign w_irq_edge = trap_trigger & ~r_trig_q;

  always_comb begin
    w_br_valid = 1'b1;
    w_br_taken = 1'b0;
    case (w_subop)
      c_br_jmp: w_br_taken = 1'b1;
      c_br_jz:  w_br_taken = r_psw[c_psw_z];
      c_br_jnz: w_br_taken = ~r_psw[c_psw_z];
      c_br_jn:  w_br_taken = r_psw[c_psw_n];
      c_br_jc:  w_br_taken = r_psw[c_psw_c];
      default:  w_br_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_opcode)
      c_op_sub: w_alu_op = ALU_SUB;
      c_op_and: w_alu_op = ALU_AND;
      default:  w_alu_op = ALU_ADD;
    endcase
  end

  cpu_alu_flags #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (r_acc),
    .b      (mem_rdata),
    .op     (w_alu_op),
    .result (w_alu_result),
    .n      (w_alu_n),
    .z      (w_alu_z),
    .c      (w_alu_c)
  );

  // Each memory state spends its first cycle launching the request, so the
  // interrupt check in FETCH never has to withdraw a request already issued.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_state       <= ST_FETCH;
      r_pc          <= c_reset_pc;
      r_epc         <= '0;
      r_acc         <= '0;
      r_ir0         <= '0;
      r_ir1         <= '0;
      r_psw         <= {3'b000, IE_RESET};
      r_epsw        <= '0;
      r_irq_pending <= 1'b0;
      r_trig_q      <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_io_write    <= 1'b0;
      r_io_data     <= '0;
      r_halted      <= 1'b0;
    end else begin
      r_trig_q   <= trap_trigger;
      r_io_write <= 1'b0;
      if (w_irq_edge) r_irq_pending <= 1'b1;

      case (r_state)
        ST_FETCH: begin
          if (!r_mem_req) begin
            if (r_irq_pending && r_psw[c_psw_ie]) begin
              r_irq_pending <= w_irq_edge;
              r_state       <= ST_TRAP_ENTRY;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_pc;
            end
          end else if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_ir0     <= mem_rdata;
            r_pc      <= r_pc + 1'b1;
            r_state   <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          case (w_opcode)
            c_op_in: begin
              r_acc   <= io_data_input;
              r_state <= ST_FETCH;
            end
            c_op_out: begin
              r_io_write <= 1'b1;
              r_io_data  <= r_acc;
              r_state    <= ST_FETCH;
            end
            c_op_trap: r_state <= ST_TRAP_ENTRY;
            c_op_reti: begin
              r_pc             <= r_epc;
              r_psw            <= r_epsw;
              r_psw[c_psw_ie]  <= 1'b1;
              r_state          <= ST_FETCH;
            end
            c_op_ld, c_op_st, c_op_add, c_op_sub, c_op_and, c_op_br:
              r_state <= ST_OPERAND;
            default: begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end
          endcase
        end

        ST_OPERAND: begin
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end else if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_ir1     <= mem_rdata;
            r_pc      <= r_pc + 1'b1;
            if (w_opcode == c_op_br) begin
              if (!w_br_valid) begin
                r_halted <= 1'b1;
                r_state  <= ST_HALT;
              end else begin
                if (w_br_taken) r_pc <= mem_rdata[ADDR_WIDTH-1:0];
                r_state <= ST_FETCH;
              end
            end else begin
              r_state <= ST_EXECUTE;
            end
          end
        end

        ST_EXECUTE: begin
          if (!r_mem_req) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_opcode == c_op_st);
            r_mem_addr  <= r_ir1[ADDR_WIDTH-1:0];
            r_mem_wdata <= r_acc;
          end else if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            case (w_opcode)
              c_op_ld: begin
                r_acc          <= mem_rdata;
                r_psw[c_psw_n] <= mem_rdata[DATA_WIDTH-1];
                r_psw[c_psw_z] <= (mem_rdata == '0);
              end
              c_op_add, c_op_sub, c_op_and: begin
                r_acc          <= w_alu_result;
                r_psw[c_psw_n] <= w_alu_n;
                r_psw[c_psw_z] <= w_alu_z;
                r_psw[c_psw_c] <= w_alu_c;
              end
              default: ;
            endcase
            r_state <= ST_FETCH;
          end
        end

        ST_TRAP_ENTRY: begin
          r_epc           <= r_pc;
          r_epsw          <= r_psw;
          r_psw[c_psw_ie] <= 1'b0;
          r_pc            <= c_trap_pc;
          r_state         <= ST_FETCH;
        end

        ST_HALT: r_state <= ST_HALT;

        default: begin
          r_halted <= 1'b1;
          r_state  <= ST_HALT;
        end
      endcase
    end
  end

  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign io_write       = r_io_write;
  assign io_data_output = r_io_data;
  assign halted         = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_cpu_acc_param.sv
// ============================================================================
// Module   : tb_cpu_acc_param
// Purpose  : Directed program tests for cpu_acc_param (8-bit configuration).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_acc_param;

  logic       clk = 1'b0;
  logic       async_nreset = 1'b0;
  logic [7:0] mem_rdata;
  logic       mem_ready = 1'b0;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] io_data_input = 8'h00;
  logic [7:0] io_data_output;
  logic       io_write;
  logic       trap_trigger = 1'b0;
  logic       halted;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem  [256];
  logic [7:0] prog [256];
  logic       load_now = 1'b0;
  int         wait_states = 0;
  int         wcnt = 0;
  logic [7:0] cap_addr;
  logic       cap_we;
  int         writes = 0;
  int         io_cnt = 0;
  logic [7:0] io_last = 8'h00;
  logic       ie_at_reti = 1'bx;

  always #5 clk = ~clk;

  cpu_acc_param dut (
    .clk            (clk),
    .async_nreset   (async_nreset),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .io_data_input  (io_data_input),
    .io_data_output (io_data_output),
    .io_write       (io_write),
    .trap_trigger   (trap_trigger),
    .halted         (halted)
  );

  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (load_now) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
    end else if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr] <= mem_wdata;
      writes <= writes + 1;
    end
  end

  // Wait-state memory responder plus IO and handler monitors
  always @(negedge clk) begin
    if (!mem_req) begin
      wcnt      = 0;
      mem_ready = 1'b0;
    end else begin
      if (wcnt == 0) begin
        cap_addr = mem_addr;
        cap_we   = mem_we;
      end else begin
        check("req_addr_stable", mem_addr, cap_addr);
        check("req_we_stable", mem_we, cap_we);
      end
      mem_ready = (wcnt >= wait_states);
      wcnt++;
    end
    if (io_write) begin
      io_cnt++;
      io_last = io_data_output;
    end
    if (mem_req && !mem_we && mem_addr == 8'hF2) ie_at_reti = dut.r_psw[0];
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 8'h90;
  endtask

  task automatic do_reset();
    async_nreset = 1'b0;
    load_now = 1'b1;
    @(posedge clk);
    #1 load_now = 1'b0;
    repeat (2) @(negedge clk);
    async_nreset = 1'b1;
  endtask

  task automatic run_to_halt(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (halted === 1'b1) break;
    end
    check({tag, "_halted"}, halted, 1);
  endtask

  task automatic run_t1(input int ws);
    int wbase;
    clear_prog();
    prog[8'h00] = 8'h00; prog[8'h01] = 8'h80;
    prog[8'h02] = 8'h40; prog[8'h03] = 8'h81;
    prog[8'h04] = 8'h10; prog[8'h05] = 8'h82;
    prog[8'h80] = 8'h7F; prog[8'h81] = 8'h01; prog[8'h82] = 8'h00;
    wait_states = ws;
    do_reset();
    wbase = writes;
    run_to_halt("t1");
    check("t1_mem82", mem[8'h82], 8'h80);
    check("t1_acc", dut.r_acc, 8'h80);
    check("t1_psw", dut.r_psw, 4'b1000);
    check("t1_pc", dut.r_pc, 8'h07);
    check("t1_writes", writes - wbase, 1);
  endtask

  initial begin
    int wbase;
    int iobase;
    int reqs;
    bit found;

    // Reset state
    clear_prog();
    async_nreset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {mem_req, mem_we, mem_addr, mem_wdata, io_write, io_data_output, halted}, 0);
    check("rst_pc", dut.r_pc, 8'h00);
    check("rst_acc", dut.r_acc, 8'h00);
    check("rst_psw", dut.r_psw, 4'b0000);

    // LD/ADD/ST, zero-wait then three wait states
    run_t1(0);
    run_t1(3);
    wait_states = 0;

    // SUB to zero, JZ taken, JNZ not taken
    clear_prog();
    prog[8'h00] = 8'h00; prog[8'h01] = 8'h80;
    prog[8'h02] = 8'h50; prog[8'h03] = 8'h81;
    prog[8'h04] = 8'h62; prog[8'h05] = 8'h40;
    prog[8'h40] = 8'h63; prog[8'h41] = 8'h50;
    prog[8'h80] = 8'h05; prog[8'h81] = 8'h05;
    do_reset();
    run_to_halt("t2");
    check("t2_acc", dut.r_acc, 8'h00);
    check("t2_psw", dut.r_psw, 4'b0110);
    check("t2_pc", dut.r_pc, 8'h43);

    // ADD with carry, JC taken, AND clears C, JN not taken
    clear_prog();
    prog[8'h00] = 8'h00; prog[8'h01] = 8'h80;
    prog[8'h02] = 8'h40; prog[8'h03] = 8'h81;
    prog[8'h04] = 8'h65; prog[8'h05] = 8'h30;
    prog[8'h30] = 8'h70; prog[8'h31] = 8'h82;
    prog[8'h32] = 8'h64; prog[8'h33] = 8'h50;
    prog[8'h80] = 8'hF3; prog[8'h81] = 8'h3C; prog[8'h82] = 8'h0F;
    do_reset();
    run_to_halt("t2b");
    check("t2b_acc", dut.r_acc, 8'h0F);
    check("t2b_psw", dut.r_psw, 4'b0000);
    check("t2b_pc", dut.r_pc, 8'h35);

    // Software TRAP/RETI enables IE, then an interrupt during ADD
    clear_prog();
    prog[8'h00] = 8'hF0;
    prog[8'h01] = 8'h00; prog[8'h02] = 8'h80;
    prog[8'h03] = 8'h40; prog[8'h04] = 8'h81;
    prog[8'h05] = 8'h30;
    prog[8'hF0] = 8'h10; prog[8'hF1] = 8'h90; prog[8'hF2] = 8'hE0;
    prog[8'h80] = 8'h10; prog[8'h81] = 8'h01; prog[8'h90] = 8'h55;
    do_reset();
    wbase = writes;
    iobase = io_cnt;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 8'h81) begin
        found = 1'b1;
        break;
      end
    end
    check("t3_add_seen", found, 1);
    trap_trigger = 1'b1;
    repeat (2) @(negedge clk);
    trap_trigger = 1'b0;
    run_to_halt("t3");
    check("t3_isr_store", mem[8'h90], 8'h11);
    check("t3_writes", writes - wbase, 2);
    check("t3_epc", dut.r_epc, 8'h05);
    check("t3_ie_in_isr", ie_at_reti, 0);
    check("t3_psw", dut.r_psw, 4'b0001);
    check("t3_out", io_last, 8'h11);
    check("t3_outcnt", io_cnt - iobase, 1);
    check("t3_pc", dut.r_pc, 8'h07);

    // Illegal opcode halts with no further memory traffic
    clear_prog();
    prog[8'h00] = 8'h95;
    do_reset();
    run_to_halt("t4");
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    check("t4_no_req", reqs, 0);
    check("t4_pc", dut.r_pc, 8'h01);

    // Illegal BR sub-op halts after the operand fetch
    clear_prog();
    prog[8'h00] = 8'h61; prog[8'h01] = 8'h00;
    do_reset();
    run_to_halt("t4b");
    check("t4b_pc", dut.r_pc, 8'h02);

    // Reset in the middle of a wait-stated store aborts it
    clear_prog();
    prog[8'h00] = 8'h10; prog[8'h01] = 8'h82; prog[8'h82] = 8'h77;
    wait_states = 3;
    do_reset();
    wbase = writes;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_store_seen", found, 1);
    async_nreset = 1'b0;
    #1;
    check("t5_req_dropped", {mem_req, mem_we}, 2'b00);
    check("t5_pc", dut.r_pc, 8'h00);
    repeat (5) @(negedge clk);
    check("t5_no_write", writes - wbase, 0);
    check("t5_mem82", mem[8'h82], 8'h77);
    wait_states = 0;

    // OUT strobe and IN load
    clear_prog();
    prog[8'h00] = 8'h00; prog[8'h01] = 8'h80;
    prog[8'h02] = 8'h30; prog[8'h03] = 8'h20;
    prog[8'h80] = 8'hA5;
    io_data_input = 8'h3C;
    do_reset();
    iobase = io_cnt;
    run_to_halt("t6");
    check("t6_outcnt", io_cnt - iobase, 1);
    check("t6_outdata", io_last, 8'hA5);
    check("t6_acc", dut.r_acc, 8'h3C);
    check("t6_psw", dut.r_psw, 4'b1000);
    check("t6_pc", dut.r_pc, 8'h05);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
